// File: rtl/core_pkg.sv
// Shared definitions for the core control path: sequencer state encodings,
// mcause codes and PC-source select values. Also used by regfile/decoder.
package core_pkg;

    typedef enum logic [2:0] {
        ST_FETCH      = 3'b000,
        ST_DECODE     = 3'b001,
        ST_EXECUTE    = 3'b010,
        ST_WRITE_BACK = 3'b011,
        ST_MEM_WAIT   = 3'b100,
        ST_TRAP       = 3'b101
    } state_t;

    localparam logic [3:0] CAUSE_NONE           = 4'd0;
    localparam logic [3:0] CAUSE_IFETCH_FAULT   = 4'd1;
    localparam logic [3:0] CAUSE_ILLEGAL        = 4'd2;
    localparam logic [3:0] CAUSE_BREAKPOINT     = 4'd3;
    localparam logic [3:0] CAUSE_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] CAUSE_LOAD_FAULT     = 4'd5;
    localparam logic [3:0] CAUSE_STORE_MISALIGN = 4'd6;
    localparam logic [3:0] CAUSE_STORE_FAULT    = 4'd7;
    localparam logic [3:0] CAUSE_ECALL          = 4'd11;

    localparam logic PC_SEL_NEXT = 1'b0;
    localparam logic PC_SEL_TRAP = 1'b1;

    // Data-side fault code depends only on access direction.
    function automatic logic [3:0] mem_fault_cause(input logic is_store);
        return is_store ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;
    endfunction

    function automatic logic [3:0] misalign_cause(input logic is_store);
        return is_store ? CAUSE_STORE_MISALIGN : CAUSE_LOAD_MISALIGN;
    endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// Instruction/data memory handshake bundle between the sequencer (master)
// and the memory ports (slave). Requests are levels held until ready.
interface core_sequencer_if;
    logic imem_req;
    logic imem_ready;
    logic imem_err;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ready;
    logic dmem_err;

    modport master (
        output imem_req, dmem_req, dmem_we,
        input  imem_ready, imem_err, dmem_ready, dmem_err
    );

    modport slave (
        input  imem_req, dmem_req, dmem_we,
        output imem_ready, imem_err, dmem_ready, dmem_err
    );
endinterface

// File: rtl/core_seq_wait_timer.sv
// Memory wait counter for the sequencer. Cleared while the sequencer is not
// waiting on memory; counts stalled cycles; flags the cycle on which the
// stall reaches TIMEOUT_CYC so the sequencer can trap on the next edge.
module core_seq_wait_timer #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYC + 1);

    logic [W-1:0] count_q, count_d;

    // Next count: hold at zero outside wait states, step on each stalled cycle.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_en) begin
            count_d = count_q + 1'b1;
        end
    end

    assign expired = count_en && !clear && (count_q == W'(TIMEOUT_CYC - 1));

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for the unprivileged core: fetch/decode/execute/
// memory/write-back sequencing, PC update select, synchronous traps and the
// instret counter. Optional memory wait timeout: CORE_SEQ_MEM_TIMEOUT_EN.
module core_sequencer
    import core_pkg::*;
#(
    parameter int CNT_W = 32
`ifdef CORE_SEQ_MEM_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 255
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    core_sequencer_if.master mem,
    input  logic             dec_illegal,
    input  logic             dec_ecall,
    input  logic             dec_ebreak,
    input  logic             dec_load,
    input  logic             dec_store,
    input  logic             dec_wr_rd,
    input  logic             ex_misalign,
    output logic [2:0]       state,
    output logic             ir_load,
    output logic             reg_write,
    output logic             pc_en,
    output logic             pc_sel,
    output logic             trap_valid,
    output logic [3:0]       trap_cause,
    output logic [CNT_W-1:0] instret
);
    state_t           state_q, state_d;
    logic [3:0]       cause_q, cause_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             ld_q, ld_d;
    logic             st_q, st_d;
    logic             wr_q, wr_d;
    // Low through reset and the first edge after release, so no fetch is
    // requested before the core has seen a clock.
    logic             active_q, active_d;

    logic             imem_req_c;
    logic             dmem_req_c;
    logic             dmem_we_c;
    logic             timeout_hit;

`ifdef CORE_SEQ_MEM_TIMEOUT_EN
    logic wait_clear;
    logic wait_en;

    assign wait_clear = !((state_q == ST_FETCH) || (state_q == ST_MEM_WAIT));
    assign wait_en    = ((state_q == ST_FETCH) && imem_req_c && !mem.imem_ready) ||
                        ((state_q == ST_MEM_WAIT) && !mem.dmem_ready);

    core_seq_wait_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wait_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (wait_clear),
        .count_en (wait_en),
        .expired  (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state, trap capture, retire count and per-state strobes.
    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        instret_d  = instret_q;
        ld_d       = ld_q;
        st_d       = st_q;
        wr_d       = wr_q;
        active_d   = 1'b1;
        imem_req_c = 1'b0;
        dmem_req_c = 1'b0;
        dmem_we_c  = 1'b0;
        ir_load    = 1'b0;
        reg_write  = 1'b0;
        pc_en      = 1'b0;
        pc_sel     = PC_SEL_NEXT;
        trap_valid = 1'b0;

        case (state_q)
            ST_FETCH: begin
                imem_req_c = run && active_q;
                // ready without an outstanding request is ignored; err wins over ready
                if (imem_req_c && mem.imem_ready) begin
                    if (mem.imem_err) begin
                        state_d = ST_TRAP;
                        cause_d = CAUSE_IFETCH_FAULT;
                    end else begin
                        ir_load = 1'b1;
                        state_d = ST_DECODE;
                    end
                end else if (timeout_hit) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_IFETCH_FAULT;
                end
            end

            ST_DECODE: begin
                ld_d = dec_load;
                st_d = dec_store;
                wr_d = dec_wr_rd;
                if (dec_illegal) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else if (dec_ebreak) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_BREAKPOINT;
                end else if (dec_ecall) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ECALL;
                end else begin
                    state_d = ST_EXECUTE;
                end
            end

            ST_EXECUTE: begin
                if ((ld_q || st_q) && ex_misalign) begin
                    state_d = ST_TRAP;
                    cause_d = misalign_cause(st_q);
                end else if (ld_q || st_q) begin
                    state_d = ST_MEM_WAIT;
                end else begin
                    state_d = ST_WRITE_BACK;
                end
            end

            ST_MEM_WAIT: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = st_q;
                if (mem.dmem_ready) begin
                    if (mem.dmem_err) begin
                        state_d = ST_TRAP;
                        cause_d = mem_fault_cause(st_q);
                    end else begin
                        state_d = ST_WRITE_BACK;
                    end
                end else if (timeout_hit) begin
                    state_d = ST_TRAP;
                    cause_d = mem_fault_cause(st_q);
                end
            end

            ST_WRITE_BACK: begin
                reg_write = wr_q && !st_q;
                pc_en     = 1'b1;
                pc_sel    = PC_SEL_NEXT;
                instret_d = instret_q + 1'b1;
                state_d   = ST_FETCH;
            end

            ST_TRAP: begin
                trap_valid = 1'b1;
                pc_en      = 1'b1;
                pc_sel     = PC_SEL_TRAP;
                state_d    = ST_FETCH;
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Control state registers; async reset abandons any outstanding access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            cause_q   <= CAUSE_NONE;
            instret_q <= '0;
            ld_q      <= 1'b0;
            st_q      <= 1'b0;
            wr_q      <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            instret_q <= instret_d;
            ld_q      <= ld_d;
            st_q      <= st_d;
            wr_q      <= wr_d;
            active_q  <= active_d;
        end
    end

    assign state        = state_q;
    assign trap_cause   = cause_q;
    assign instret      = instret_q;
    assign mem.imem_req = imem_req_c;
    assign mem.dmem_req = dmem_req_c;
    assign mem.dmem_we  = dmem_we_c;
endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer. Inputs change on the falling edge and
// outputs are sampled 1 ns later. CNT_W=2 so instret wrap is reachable.
module tb_core_sequencer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic       dec_illegal, dec_ecall, dec_ebreak, dec_load, dec_store, dec_wr_rd;
    logic       ex_misalign;
    logic [2:0] state;
    logic       ir_load, reg_write, pc_en, pc_sel, trap_valid;
    logic [3:0] trap_cause;
    logic [1:0] instret;

    int n_tests = 0;
    int n_fail  = 0;

    core_sequencer_if mif ();

    core_sequencer #(
        .CNT_W (2)
`ifdef CORE_SEQ_MEM_TIMEOUT_EN
        , .TIMEOUT_CYC (8)
`endif
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .mem         (mif),
        .dec_illegal (dec_illegal),
        .dec_ecall   (dec_ecall),
        .dec_ebreak  (dec_ebreak),
        .dec_load    (dec_load),
        .dec_store   (dec_store),
        .dec_wr_rd   (dec_wr_rd),
        .ex_misalign (ex_misalign),
        .state       (state),
        .ir_load     (ir_load),
        .reg_write   (reg_write),
        .pc_en       (pc_en),
        .pc_sel      (pc_sel),
        .trap_valid  (trap_valid),
        .trap_cause  (trap_cause),
        .instret     (instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_dec();
        dec_illegal = 1'b0; dec_ecall = 1'b0; dec_ebreak = 1'b0;
        dec_load = 1'b0; dec_store = 1'b0; dec_wr_rd = 1'b0;
    endtask

    // Fetch with immediate ready, present decoder flags in DECODE, then return
    // on the falling edge of the cycle after DECODE with all inputs cleared.
    task automatic fetch_decode(input logic ld, st, wr, ill, eb, ec);
        @(negedge clk);
        mif.imem_ready = 1'b1;
        #1 chk("fetch_ir_load", ir_load, 1);
        @(negedge clk);
        mif.imem_ready = 1'b0;
        dec_load = ld; dec_store = st; dec_wr_rd = wr;
        dec_illegal = ill; dec_ebreak = eb; dec_ecall = ec;
        #1 chk("decode_state", state, 3'b001);
        @(negedge clk);
        clear_dec();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; run = 1'b1; ex_misalign = 1'b0;
        clear_dec();
        mif.imem_ready = 1'b0; mif.imem_err = 1'b0;
        mif.dmem_ready = 1'b0; mif.dmem_err = 1'b0;

        // reset state
        #2;
        chk("rst_state", state, 3'b000);
        chk("rst_imem_req", mif.imem_req, 0);
        chk("rst_dmem_req", mif.dmem_req, 0);
        chk("rst_pc_en", pc_en, 0);
        chk("rst_cause", trap_cause, 0);
        chk("rst_instret", instret, 0);

        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("release_no_req", mif.imem_req, 0);
        @(negedge clk);
        #1 chk("first_req", mif.imem_req, 1);

        // ALU op: 000,001,010,011,000
        fetch_decode(0, 0, 1, 0, 0, 0);
        #1 chk("alu_execute", state, 3'b010);
        chk("alu_exe_regwr", reg_write, 0);
        @(negedge clk);
        #1 chk("alu_wb", state, 3'b011);
        chk("alu_wb_regwr", reg_write, 1);
        chk("alu_wb_pc_en", pc_en, 1);
        chk("alu_wb_pc_sel", pc_sel, 0);
        chk("alu_wb_instret", instret, 0);
        @(negedge clk);
        #1 chk("alu_fetch", state, 3'b000);
        chk("alu_instret", instret, 1);

        // run=0 holds in FETCH, ready ignored without request
        run = 1'b0; mif.imem_ready = 1'b1;
        #1 chk("run0_req", mif.imem_req, 0);
        chk("run0_ir_load", ir_load, 0);
        @(negedge clk);
        #1 chk("run0_hold", state, 3'b000);
        run = 1'b1; mif.imem_ready = 1'b0;

        // load with 3 wait cycles; stray dmem_ready in EXECUTE is ignored
        fetch_decode(1, 0, 1, 0, 0, 0);
        mif.dmem_ready = 1'b1;
        #1 chk("ld_execute", state, 3'b010);
        chk("ld_exe_dreq", mif.dmem_req, 0);
        @(negedge clk);
        mif.dmem_ready = 1'b0;
        #1 chk("ld_memwait1", state, 3'b100);
        chk("ld_dreq", mif.dmem_req, 1);
        chk("ld_dwe", mif.dmem_we, 0);
        @(negedge clk);
        #1 chk("ld_memwait2", state, 3'b100);
        @(negedge clk);
        #1 chk("ld_memwait3", state, 3'b100);
        @(negedge clk);
        mif.dmem_ready = 1'b1;
        #1 chk("ld_memwait4", state, 3'b100);
        @(negedge clk);
        mif.dmem_ready = 1'b0;
        #1 chk("ld_wb", state, 3'b011);
        chk("ld_wb_regwr", reg_write, 1);
        @(negedge clk);
        #1 chk("ld_instret", instret, 2);

        // store: dmem_we=1, no regfile write
        fetch_decode(0, 1, 1, 0, 0, 0);
        @(negedge clk);
        mif.dmem_ready = 1'b1;
        #1 chk("st_memwait", state, 3'b100);
        chk("st_dwe", mif.dmem_we, 1);
        @(negedge clk);
        mif.dmem_ready = 1'b0;
        #1 chk("st_wb", state, 3'b011);
        chk("st_wb_regwr", reg_write, 0);
        chk("st_wb_pc_en", pc_en, 1);
        @(negedge clk);
        #1 chk("st_instret", instret, 3);

        // illegal (with ecall also set) -> cause 2
        fetch_decode(0, 0, 1, 1, 0, 1);
        #1 chk("ill_trap", state, 3'b101);
        chk("ill_cause", trap_cause, 2);
        chk("ill_trap_valid", trap_valid, 1);
        chk("ill_pc_en", pc_en, 1);
        chk("ill_pc_sel", pc_sel, 1);
        chk("ill_regwr", reg_write, 0);
        @(negedge clk);
        #1 chk("ill_fetch", state, 3'b000);
        chk("ill_valid_drop", trap_valid, 0);
        chk("ill_cause_held", trap_cause, 2);
        chk("ill_instret", instret, 3);

        // ebreak beats ecall -> cause 3
        fetch_decode(0, 0, 0, 0, 1, 1);
        #1 chk("ebreak_cause", trap_cause, 3);

        // ecall alone -> cause 11
        fetch_decode(0, 0, 0, 0, 0, 1);
        #1 chk("ecall_cause", trap_cause, 11);

        // load data fault: ready and err together -> cause 5
        fetch_decode(1, 0, 1, 0, 0, 0);
        @(negedge clk);
        mif.dmem_ready = 1'b1; mif.dmem_err = 1'b1;
        #1 chk("ldf_memwait", state, 3'b100);
        @(negedge clk);
        mif.dmem_ready = 1'b0; mif.dmem_err = 1'b0;
        #1 chk("ldf_trap", state, 3'b101);
        chk("ldf_cause", trap_cause, 5);
        chk("ldf_regwr", reg_write, 0);
        @(negedge clk);
        #1 chk("ldf_instret", instret, 3);

        // store data fault -> cause 7
        fetch_decode(0, 1, 0, 0, 0, 0);
        @(negedge clk);
        mif.dmem_ready = 1'b1; mif.dmem_err = 1'b1;
        @(negedge clk);
        mif.dmem_ready = 1'b0; mif.dmem_err = 1'b0;
        #1 chk("stf_cause", trap_cause, 7);

        // misaligned store -> cause 6
        fetch_decode(0, 1, 0, 0, 0, 0);
        ex_misalign = 1'b1;
        #1 chk("mis_execute", state, 3'b010);
        @(negedge clk);
        ex_misalign = 1'b0;
        #1 chk("mis_st_trap", state, 3'b101);
        chk("mis_st_cause", trap_cause, 6);

        // misaligned load -> cause 4
        fetch_decode(1, 0, 1, 0, 0, 0);
        ex_misalign = 1'b1;
        @(negedge clk);
        ex_misalign = 1'b0;
        #1 chk("mis_ld_cause", trap_cause, 4);

        // instruction access fault -> cause 1
        @(negedge clk);
        mif.imem_ready = 1'b1; mif.imem_err = 1'b1;
        #1 chk("ifault_ir_load", ir_load, 0);
        @(negedge clk);
        mif.imem_ready = 1'b0; mif.imem_err = 1'b0;
        #1 chk("ifault_trap", state, 3'b101);
        chk("ifault_cause", trap_cause, 1);

        // fourth retirement wraps the 2-bit counter
        fetch_decode(0, 0, 1, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        #1 chk("instret_wrap", instret, 0);

        // retire once more, then reset mid-MEM_WAIT
        fetch_decode(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        #1 chk("pre_rst_instret", instret, 1);
        fetch_decode(1, 0, 1, 0, 0, 0);
        @(negedge clk);
        #1 chk("rst_mw_state", state, 3'b100);
        chk("rst_mw_dreq", mif.dmem_req, 1);
        #1 rst_n = 1'b0;
        #1 chk("rst_async_state", state, 3'b000);
        chk("rst_async_dreq", mif.dmem_req, 0);
        chk("rst_async_instret", instret, 0);
        chk("rst_async_cause", trap_cause, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst2_no_req", mif.imem_req, 0);

`ifdef CORE_SEQ_MEM_TIMEOUT_EN
        // fetch never answered: 8 stalled cycles then TRAP cause 1
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            #1 chk("tmo_waiting", state, 3'b000);
        end
        @(negedge clk);
        #1 chk("tmo_trap", state, 3'b101);
        chk("tmo_cause", trap_cause, 1);
        chk("tmo_req_drop", mif.imem_req, 0);
`else
        // fetch never answered: waits indefinitely with request held
        repeat (20) @(negedge clk);
        #1 chk("nowait_state", state, 3'b000);
        chk("nowait_req", mif.imem_req, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
